// File: rtl/buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// buzzer_arbiter
//
// Four-player "first to buzz" arbiter and screen sequencer for the display
// controller. Raw buttons and vsync are synchronised. Buttons are optionally
// debounced. The first new button press in a round wins. Ties in a single
// cycle are broken round-robin. The screen outputs change only on frame
// boundaries, so a frame never tears.
//
// Optional feature macro: BUZZ_DEBOUNCE_EN
//   defined   : each synchronised button must hold a new level for DEB_CYCLES
//               consecutive clocks before it is accepted (16-bit counters)
//   undefined : synchronised buttons are used directly, no counters are built
//
// Parameters
//   DEB_CYCLES  clocks a synchronised button must hold a level (<= 65536)
//   ARM_FRAMES  frames spent armed before timing out           (<= 1024)
//   WIN_FRAMES  frames the winner/timeout screen is displayed   (<= 1024)
//
// Ports
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   start            in   one-cycle pulse, arms a round (IDLE only)
//   p1Btn..p4Btn     in   raw asynchronous player buttons, active-high
//   vsync            in   VGA vsync, active-low; falling edge = frame
//   screenStatus     out  0 title, 1 armed, 2 winner, 3 timeout (frame-aligned)
//   winnerPlayerNum  out  winner index 0..3 = p1..p4 (frame-aligned)
//   winnerValid      out  one-cycle pulse on the clock a winner is latched
//   busy             out  high whenever the FSM is not IDLE
//   fsm_state        out  debug: current FSM state (0 IDLE 1 ARMED 2 WIN 3 TMO)
//   rr_ptr           out  debug: current round-robin start index
// -----------------------------------------------------------------------------
module buzzer_arbiter #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned ARM_FRAMES = 600,
    parameter int unsigned WIN_FRAMES = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p1Btn,
    input  logic       p2Btn,
    input  logic       p3Btn,
    input  logic       p4Btn,
    input  logic       vsync,
    output logic [1:0] screenStatus,
    output logic [1:0] winnerPlayerNum,
    output logic       winnerValid,
    output logic       busy,
    output logic [1:0] fsm_state,
    output logic [1:0] rr_ptr
);

    // State encoding equals the screenStatus code shown for that state.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_WIN   = 2'd2,
        S_TMO   = 2'd3
    } state_t;

    localparam logic [9:0] ARM_LAST = 10'(ARM_FRAMES - 1);
    localparam logic [9:0] WIN_LAST = 10'(WIN_FRAMES - 1);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    logic [3:0] btn_raw;
    logic [3:0] btn_s1;
    logic [3:0] btn_s2;
    logic       vs_s1;
    logic       vs_s2;
    logic       vs_d;
    logic       frame;

    assign btn_raw = {p4Btn, p3Btn, p2Btn, p1Btn};

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            vs_s1  <= 1'b0;
            vs_s2  <= 1'b0;
            vs_d   <= 1'b0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            vs_s1  <= vsync;
            vs_s2  <= vs_s1;
            vs_d   <= vs_s2;
        end
    end

    // Frame boundary: falling edge of the synchronised (active-low) vsync.
    assign frame = vs_d & ~vs_s2;

    // -------------------------------------------------------------------------
    // Debounce filter -> btn_q
    // -------------------------------------------------------------------------
    logic [3:0] btn_q;

`ifdef BUZZ_DEBOUNCE_EN
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    logic [15:0] deb_cnt [4];

    // The counter runs only while the synced level differs from the accepted
    // level. A return to the accepted level restarts it from zero. The counter
    // never exceeds DEB_LAST, because reaching it accepts the level and clears
    // the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == btn_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    btn_q[i]   <= btn_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 16'd1;
                end
            end
        end
    end
`else
    assign btn_q = btn_s2;

    // This build ignores DEB_CYCLES. An out-of-range value still elaborates
    // an empty marker block, so a bad parameter set shows in the hierarchy.
    if (DEB_CYCLES == 0 || DEB_CYCLES > 65536) begin : g_deb_cycles_illegal
    end
`endif

    // -------------------------------------------------------------------------
    // Press detection and round-robin pick
    // -------------------------------------------------------------------------
    logic [3:0] btn_q_d;
    logic [3:0] press;
    logic       any_press;
    logic [1:0] pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q_d <= '0;
        end else begin
            btn_q_d <= btn_q;
        end
    end

    assign press     = btn_q & ~btn_q_d;
    assign any_press = |press;

    // Search press[] starting at rr_ptr and wrapping modulo 4.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && press[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register / next-state logic / outputs
    // -------------------------------------------------------------------------
    state_t     state;
    state_t     state_next;
    logic [9:0] frame_cnt;
    logic       shown;
    logic       arm_timeout;
    logic       hold_done;

    // The winner and timeout screens count their hold time only on frames
    // where the screen already displays them. This holds the screen for
    // WIN_FRAMES frames, whether the state was entered on a frame or between
    // frames.
    assign shown       = (screenStatus == 2'(state));
    assign arm_timeout = frame && (frame_cnt == ARM_LAST);
    assign hold_done   = frame && shown && (frame_cnt == WIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                // A press on the timeout frame still wins.
                if (any_press) begin
                    state_next = S_WIN;
                end else if (arm_timeout) begin
                    state_next = S_TMO;
                end
            end
            S_WIN, S_TMO: begin
                if (hold_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        winnerValid = ~rst & (state == S_ARMED) & any_press;
        busy        = (state != S_IDLE);
        fsm_state   = state;
    end

    // -------------------------------------------------------------------------
    // Frame counter, winner latch, round-robin pointer
    // -------------------------------------------------------------------------
    logic [1:0] winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state != state_next) begin
            frame_cnt <= '0;
        end else if (frame && frame_cnt != CNT_MAX) begin
            if (state == S_ARMED || ((state == S_WIN || state == S_TMO) && shown)) begin
                frame_cnt <= frame_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner <= '0;
            rr_ptr <= '0;
        end else if (state == S_ARMED && any_press) begin
            winner <= pick;
            rr_ptr <= pick + 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame-aligned screen outputs
    // -------------------------------------------------------------------------
    logic [1:0] next_status;
    logic [1:0] next_winner;

    assign next_status = 2'(state_next);
    assign next_winner = (state == S_ARMED && any_press) ? pick : winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            screenStatus    <= '0;
            winnerPlayerNum <= '0;
        end else if (frame) begin
            screenStatus    <= next_status;
            winnerPlayerNum <= next_winner;
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buzzer_arbiter
//
// Bench for buzzer_arbiter with small parameters (DEB_CYCLES=4, ARM_FRAMES=5,
// WIN_FRAMES=3) and a 100-clock vsync period. A table of rounds drives the
// stimulus. Each round pushes its expected {screenStatus, winnerPlayerNum}
// result into exp_q. A monitor pops that value when the result screen
// appears. Hand-written sequences cover reset mid-round and the debounce
// glitch cases.
// -----------------------------------------------------------------------------
module tb_buzzer_arbiter;

    localparam int DEB  = 4;
    localparam int ARM  = 5;
    localparam int WINF = 3;
`ifdef BUZZ_DEBOUNCE_EN
    localparam int PRESS_LAT = 2 + DEB;
`else
    localparam int PRESS_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       p1Btn, p2Btn, p3Btn, p4Btn;
    logic       vsync;
    logic [1:0] screenStatus;
    logic [1:0] winnerPlayerNum;
    logic       winnerValid;
    logic       busy;
    logic [1:0] fsm_state;
    logic [1:0] rr_ptr;

    buzzer_arbiter #(
        .DEB_CYCLES (DEB),
        .ARM_FRAMES (ARM),
        .WIN_FRAMES (WINF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .p1Btn           (p1Btn),
        .p2Btn           (p2Btn),
        .p3Btn           (p3Btn),
        .p4Btn           (p4Btn),
        .vsync           (vsync),
        .screenStatus    (screenStatus),
        .winnerPlayerNum (winnerPlayerNum),
        .winnerValid     (winnerValid),
        .busy            (busy),
        .fsm_state       (fsm_state),
        .rr_ptr          (rr_ptr)
    );

    // ---------------- clock / vsync ----------------
    always #5 clk = ~clk;

    int  frames    = 0;
    time last_fall = 0;

    initial begin
        vsync = 1'b1;
        forever begin
            repeat (90) @(negedge clk);
            vsync     = 1'b0;
            frames    = frames + 1;
            last_fall = $time;
            repeat (10) @(negedge clk);
            vsync = 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    int         wv_cnt    = 0;
    int         res_frame = -1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    logic [1:0] prev_st  = 2'd0;
    logic [1:0] prev_wn  = 2'd0;
    logic       rst_prev = 1'b1;

    always @(negedge clk) begin
        time        age;
        logic [3:0] e;
        if (!rst && !rst_prev && (screenStatus != prev_st || winnerPlayerNum != prev_wn)) begin
            // Screen outputs may only move a few clocks after a vsync fall.
            age = $time - last_fall;
            checks++;
            if (age < 5 || age > 45) begin
                errors++;
                $display("FAIL frame_align status=%0d change %0t after vsync fall, required within 5..45",
                         screenStatus, age);
            end
            if (screenStatus >= 2'd2 && prev_st <= 2'd1) begin
                res_frame = frames;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result status=%0d winner=%0d required none",
                             screenStatus, winnerPlayerNum);
                end else begin
                    e = exp_q.pop_front();
                    check("result_status", int'(screenStatus), int'(e[3:2]));
                    check("result_winner", int'(winnerPlayerNum), int'(e[1:0]));
                end
            end
            if (screenStatus == 2'd0 && prev_st >= 2'd2) begin
                check("hold_frames", frames - res_frame, WINF);
            end
        end
        if (winnerValid) wv_cnt++;
        prev_st  = screenStatus;
        prev_wn  = winnerPlayerNum;
        rst_prev = rst;
    end

    // ---------------- driver tasks ----------------
    task automatic set_btns(input logic [3:0] b);
        {p4Btn, p3Btn, p2Btn, p1Btn} = b;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s busy still 1 after %0d clk, required 0", name, budget);
        end
    endtask

    // Start a round a few clocks after the DUT has taken a vsync fall.
    task automatic sync_to_frame();
        int f_now = frames;
        int n = 0;
        while (frames == f_now && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5 + $urandom_range(0, 15)) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] held;        // buttons raised before start and held all round
        int         lead;        // clocks between raising held and start
        logic [3:0] btns;        // buttons rising together 20 clk after start
        bit         poke;        // pulse start while the winner screen is up
        logic [1:0] exp_status;
        logic [1:0] exp_winner;
        logic [1:0] exp_rr;
    } vec_t;

    vec_t vecs[11];

    task automatic run_round(input vec_t v, input int idx);
        int f0;
        int wv0;
        wait_idle(2000, "idle_before_round");
        sync_to_frame();
        if (v.held != 4'b0000) begin
            set_btns(v.held);
            repeat (v.lead) @(negedge clk);
        end
        f0  = frames;
        wv0 = wv_cnt;
        exp_q.push_back({v.exp_status, v.exp_winner});
        pulse_start();
        check("armed_busy", int'(busy), 1);
        check("armed_state", int'(fsm_state), 1);
        if (v.btns != 4'b0000) begin
            repeat (20) @(negedge clk);
            set_btns(v.btns);
            repeat (10) @(negedge clk);
            set_btns(4'b0000);
            if (v.poke) begin
                repeat (30) @(negedge clk);
                check("poke_in_win_state", int'(fsm_state), 2);
                pulse_start();
            end
        end
        wait_idle(1500, "round_end");
        check("round_wv_pulses", wv_cnt - wv0, (v.btns != 4'b0000) ? 1 : 0);
        check("round_rr_ptr", int'(rr_ptr), int'(v.exp_rr));
        check("round_end_screen", int'(screenStatus), 0);
        if (v.btns == 4'b0000) begin
            check("timeout_frames", res_frame - f0, ARM);
        end
        set_btns(4'b0000);
        if (v.poke) begin
            repeat (250) @(negedge clk);
            check("poke_ignored_busy", int'(busy), 0);
            check("poke_ignored_screen", int'(screenStatus), 0);
        end
        if (errors != 0) $display("note: errors so far %0d after round %0d", errors, idx);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wv0;
        vecs[0]  = '{4'b0000, 0,         4'b1010, 1'b0, 2'd2, 2'd1, 2'd2};
        vecs[1]  = '{4'b0000, 0,         4'b1010, 1'b0, 2'd2, 2'd3, 2'd0};
        vecs[2]  = '{4'b0000, 0,         4'b0100, 1'b1, 2'd2, 2'd2, 2'd3};
        vecs[3]  = '{4'b0000, 0,         4'b1111, 1'b0, 2'd2, 2'd3, 2'd0};
        vecs[4]  = '{4'b0000, 0,         4'b0001, 1'b0, 2'd2, 2'd0, 2'd1};
        vecs[5]  = '{4'b0000, 0,         4'b0101, 1'b0, 2'd2, 2'd2, 2'd3};
        vecs[6]  = '{4'b0000, 0,         4'b0011, 1'b0, 2'd2, 2'd0, 2'd1};
        vecs[7]  = '{4'b0001, 50,        4'b0000, 1'b0, 2'd3, 2'd0, 2'd1};
        vecs[8]  = '{4'b0010, PRESS_LAT, 4'b0000, 1'b0, 2'd3, 2'd0, 2'd1};
        vecs[9]  = '{4'b0000, 0,         4'b1001, 1'b0, 2'd2, 2'd3, 2'd0};
        vecs[10] = '{4'b0000, 0,         4'b0010, 1'b0, 2'd2, 2'd1, 2'd2};

        rst   = 1'b1;
        start = 1'b0;
        set_btns(4'b0000);
        repeat (3) @(negedge clk);
        check("reset_screen", int'(screenStatus), 0);
        check("reset_winner", int'(winnerPlayerNum), 0);
        check("reset_valid", int'(winnerValid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_state", int'(fsm_state), 0);
        check("reset_rr", int'(rr_ptr), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_round(vecs[i], i);
        end

        // Reset in the middle of an armed round.
        wait_idle(2000, "idle_before_reset_test");
        sync_to_frame();
        pulse_start();
        repeat (150) @(negedge clk);
        check("pre_reset_armed", int'(screenStatus), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_screen", int'(screenStatus), 0);
        check("midrst_winner", int'(winnerPlayerNum), 0);
        check("midrst_valid", int'(winnerValid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_state", int'(fsm_state), 0);
        check("midrst_rr", int'(rr_ptr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wv0 = wv_cnt;
        set_btns(4'b0010);
        repeat (10) @(negedge clk);
        set_btns(4'b0000);
        repeat (40) @(negedge clk);
        check("post_reset_no_win", wv_cnt - wv0, 0);
        check("post_reset_idle", int'(busy), 0);

`ifdef BUZZ_DEBOUNCE_EN
        begin
            int  n;
            bit  seen;
            sync_to_frame();
            exp_q.push_back({2'd2, 2'd3});
            pulse_start();
            repeat (20) @(negedge clk);
            wv0 = wv_cnt;
            p4Btn = 1'b1;
            repeat (2) @(negedge clk);
            p4Btn = 1'b0;
            repeat (30) @(negedge clk);
            check("deb_glitch_2clk", wv_cnt - wv0, 0);
            p4Btn = 1'b1;
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 30) begin
                @(negedge clk);
                n++;
                if (n == 6) p4Btn = 1'b0;
                if (winnerValid) seen = 1'b1;
            end
            p4Btn = 1'b0;
            check("deb_glitch_6clk_win", int'(seen), 1);
            check("deb_latency_ge_6", (n >= 6) ? 1 : 0, 1);
            wait_idle(1500, "deb_round_end");
        end
`endif

        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
